logic_op_arbiter: RTL

//  Shares one bitwise logic-op unit (AND / OR / NOT) among NREQ requesters.

---
 rtl/logic_arb_pkg.sv | 15 +
 rtl/logic_op_unit.sv | 48 ++++
 rtl/logic_op_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/logic_arb_pkg.sv
// Shared op-code constants and arbiter FSM state encoding for logic_op_arbiter.
package logic_arb_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_NOT = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise AND/OR/NOT unit; op 3 is XOR when LOGIC_ARB_XOR_EN is defined,
// otherwise op 3 yields zero with err set. No state, no handshake.
module logic_op_unit
  import logic_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         err
);

  logic [W-1:0] w_and;
  logic [W-1:0] w_or;
  logic [W-1:0] w_not;
`ifdef LOGIC_ARB_XOR_EN
  logic [W-1:0] w_xor;
`endif

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    and u_and (w_and[gi], a[gi], b[gi]);
    or  u_or  (w_or[gi],  a[gi], b[gi]);
    not u_not (w_not[gi], a[gi]);
`ifdef LOGIC_ARB_XOR_EN
    xor u_xor (w_xor[gi], a[gi], b[gi]);
`endif
  end

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND: y = w_and;
      OP_OR:  y = w_or;
      OP_NOT: y = w_not;
      default: begin
`ifdef LOGIC_ARB_XOR_EN
        y   = w_xor;
`else
        err = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit among NREQ requesters (LOGIC_ARB_XOR_EN enables op 3 XOR).
// Handshake in cycle N -> rsp_valid in N+2; requests are refused (req_ready=0) until the response is taken.
module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err
);

  localparam int SW = IDW + 1;

  state_t         r_state;
  state_t         w_next_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [1:0]     r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_data;
  logic           r_err;

  logic [1:0]     w_op_arr [NREQ];
  logic [W-1:0]   w_a_arr  [NREQ];
  logic [W-1:0]   w_b_arr  [NREQ];
  logic           w_any;
  logic           w_grant;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_ptr_nxt;
  logic [SW-1:0]  w_sum;
  logic [W-1:0]   w_y;
  logic           w_err;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_arr[gi] = req_op[2*gi +: 2];
    assign w_a_arr[gi]  = req_a[W*gi +: W];
    assign w_b_arr[gi]  = req_b[W*gi +: W];
  end

  // Scan downwards so the lowest rotated offset from r_ptr wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
      if (req_valid[w_sum[IDW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_sum[IDW-1:0];
      end
    end
  end

  // Gated by rst_n so no requester sees a grant while reset is held.
  assign w_grant   = rst_n && (r_state == IDLE) && w_any;
  assign w_ptr_nxt = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
  assign req_ready = w_grant ? (NREQ'(1) << w_winner) : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  logic_op_unit #(.W(W)) u_unit (
    .op  (r_op),
    .a   (r_a),
    .b   (r_b),
    .y   (w_y),
    .err (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_ptr <= w_ptr_nxt;
        r_id  <= w_winner;
        r_op  <= w_op_arr[w_winner];
        r_a   <= w_a_arr[w_winner];
        r_b   <= w_b_arr[w_winner];
      end
      if (r_state == EXEC) begin
        r_data <= w_y;
        r_err  <= w_err;
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

endmodule
